// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types, sizes and GF(2^8) helpers for the AES decryption round stage
package aes_dec_pkg;
    localparam int NCOL = 4;
    localparam int CW   = 32;

    typedef enum logic [1:0] {IDLE, MIX, DONE} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction
endpackage

// File: rtl/inv_addkey_mixcol_stage_if.sv
// inv_addkey_mixcol_stage_if: upstream/downstream handshake bundle of the round stage
interface inv_addkey_mixcol_stage_if;
    import aes_dec_pkg::*;
    logic                 in_valid;
    logic                 in_ready;
    logic [NCOL*CW-1:0]   in_state;
    logic [NCOL*CW-1:0]   in_key;
    logic                 in_skip_mix;
    logic                 out_valid;
    logic                 out_ready;
    logic [NCOL*CW-1:0]   out_state;
    logic                 busy;

    modport master (
        output in_valid, in_state, in_key, in_skip_mix, out_ready,
        input  in_ready, out_valid, out_state, busy
    );
    modport slave (
        input  in_valid, in_state, in_key, in_skip_mix, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/inv_mix_col_word.sv
// inv_mix_col_word: InvMixColumns on one 32-bit column, byte 0 in the MSBs
module inv_mix_col_word
    import aes_dec_pkg::*;
(
    input  logic [CW-1:0] col_i,
    output logic [CW-1:0] col_o
);
    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_i;
    assign col_o = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                    mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                    muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                    mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
endmodule

// File: rtl/inv_addkey_mixcol_stage.sv
// inv_addkey_mixcol_stage: AddRoundKey then column-serial InvMixColumns (skippable for the last round)
module inv_addkey_mixcol_stage
    import aes_dec_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    inv_addkey_mixcol_stage_if.slave  bus
);
    state_e               state_q;
    logic [1:0]           col_q;
    logic [NCOL*CW-1:0]   buf_q;
    logic [CW-1:0]        mix_in;
    logic [CW-1:0]        mix_out;

    // column 0 lives in the top word, so the word index is the inverted count
    assign mix_in = buf_q[{~col_q, 5'd0} +: CW];

    inv_mix_col_word u_mix (.col_i(mix_in), .col_o(mix_out));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    buf_q   <= bus.in_state ^ bus.in_key;
                    col_q   <= 2'd0;
                    state_q <= bus.in_skip_mix ? DONE : MIX;
                end
                MIX: begin
                    buf_q[{~col_q, 5'd0} +: CW] <= mix_out;
                    col_q                       <= col_q + 2'd1;
                    state_q                     <= (col_q == 2'd3) ? DONE : MIX;
                end
                DONE: state_q <= bus.out_ready ? IDLE : DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q != IDLE;
    assign bus.out_state = buf_q;
endmodule

// File: tb/tb_inv_addkey_mixcol_stage.sv
// tb_inv_addkey_mixcol_stage: random and directed checks against a matrix-level GF(2^8) model
module tb_inv_addkey_mixcol_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inv_addkey_mixcol_stage_if bus();
    inv_addkey_mixcol_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [127:0] v;
        int           acc_edge;
        int           lat;
    } exp_t;

    exp_t         q[$];
    int           acc_edges[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           n_out = 0;
    logic [127:0] last_out = '0;
    bit           prev_ov = 1'b0;
    bit           rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] x;
        logic [7:0] r;
        x = {1'b0, a};
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r ^= x[7:0];
            x = x << 1;
            if (x[8]) x ^= 9'h11b;
        end
        return r;
    endfunction

    // each output byte i uses coefficient c[(j-i) mod 4] on input byte j
    function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k, input bit skip);
        logic [7:0]   c[4];
        logic [7:0]   a[16];
        logic [7:0]   b;
        logic [127:0] t;
        logic [127:0] r;
        c = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        t = s ^ k;
        if (skip) return t;
        for (int n = 0; n < 16; n++) a[n] = t[127 - 8*n -: 8];
        r = '0;
        for (int col = 0; col < 4; col++)
            for (int i = 0; i < 4; i++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++) b ^= gmul(c[(j - i + 4) % 4], a[4*col + j]);
                r[127 - 8*(4*col + i) -: 8] = b;
            end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            prev_ov = 1'b0;
            chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
            chk("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
            chk("rst_busy", {127'd0, bus.busy}, 128'd0);
            chk("rst_out_state", bus.out_state, 128'd0);
        end else begin
            chk("in_ready", {127'd0, bus.in_ready}, {127'd0, q.size() == 0});
            chk("busy", {127'd0, bus.busy}, {127'd0, q.size() != 0});
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got 1 expected 0");
                end else begin
                    chk("out_state", bus.out_state, q[0].v);
                    if (!prev_ov) chk("latency", 128'(cyc - q[0].acc_edge + 1), 128'(q[0].lat));
                    if (bus.out_ready) begin
                        last_out = bus.out_state;
                        n_out++;
                        void'(q.pop_front());
                    end
                end
            end
            prev_ov = bus.out_valid && !bus.out_ready;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back('{model(bus.in_state, bus.in_key, bus.in_skip_mix), cyc + 1,
                              bus.in_skip_mix ? 1 : 5});
                acc_edges.push_back(cyc + 1);
            end
        end
    end

    always @(posedge clk) if (rnd_ready) begin
        #2 bus.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [127:0] s, input logic [127:0] k, input bit sk, input bit keep);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b1;
        bus.in_state    = s;
        bus.in_key      = k;
        bus.in_skip_mix = sk;
        @(negedge clk);
        while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int t;
        t = 0;
        while (n_out < target && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (n_out < target) begin
            checks++;
            errors++;
            $display("FAIL output_timeout: got %0d outputs expected %0d", n_out, target);
        end
    endtask

    localparam logic [127:0] V1  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] V2  = 128'h71b25e43_6023a762_fefefefe_2a2a2829;
    localparam logic [127:0] R12 = 128'hdb135345_f20a225c_01010101_d4d4d4d5;
    localparam logic [127:0] V3  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] R3  = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    localparam logic [127:0] C6  = {16{8'hc6}};

    initial begin
        int a0;
        bus.in_valid    = 1'b0;
        bus.in_state    = '0;
        bus.in_key      = '0;
        bus.in_skip_mix = 1'b0;
        bus.out_ready   = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        send(V1, '0, 1'b0, 1'b0);
        wait_out(1);
        chk("vec1", last_out, R12);
        send(V2, '1, 1'b0, 1'b0);
        wait_out(2);
        chk("vec2", last_out, R12);
        send(V3, {16{8'h0f}}, 1'b1, 1'b0);
        wait_out(3);
        chk("vec3_skip", last_out, R3);

        bus.out_ready = 1'b0;
        send(C6, '0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        a0 = acc_edges.size();
        bus.in_valid = 1'b1;
        bus.in_state = {4{32'($urandom)}};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", {127'd0, bus.out_valid}, 128'd1);
            chk("hold_state", bus.out_state, C6);
        end
        bus.in_valid = 1'b0;
        chk("ignored_input", 128'(acc_edges.size()), 128'(a0));
        bus.out_ready = 1'b1;
        wait_out(4);
        chk("fixed_point", last_out, C6);

        send({4{32'($urandom)}}, {4{32'($urandom)}}, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("async_in_ready", {127'd0, bus.in_ready}, 128'd1);
        chk("async_busy", {127'd0, bus.busy}, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(V1, '0, 1'b0, 1'b0);
        wait_out(5);
        chk("after_reset", last_out, R12);

        a0 = acc_edges.size();
        send(V1, '0, 1'b0, 1'b1);
        send(V2, '1, 1'b0, 1'b1);
        send(V3, {16{8'h0f}}, 1'b0, 1'b0);
        wait_out(8);
        chk("b2b_gap1", 128'(acc_edges[a0 + 1] - acc_edges[a0]), 128'd6);
        chk("b2b_gap2", 128'(acc_edges[a0 + 2] - acc_edges[a0 + 1]), 128'd6);
        chk("b2b_last", last_out, model(V3, {16{8'h0f}}, 1'b0));

        rnd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_out(48);
        rnd_ready = 1'b0;
        #3 bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule
